muldiv_unit: RTL

Iterative RV32M multiply/divide execute unit sitting directly downstream of the register file. It consumes the rs1/rs2 operand pair read for an M-extension instruction and computes one of the eight RV32M results over multiple cycles. It hands the result, with its destination register index, to writeback over a valid/ready handshake. The pipeline stalls on in_ready low.

---
 rtl/muldiv_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handoff to writeback.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_op/in_rs1/in_rs2/in_rd operation request;
// flush aborts the in-flight operation; out_valid/out_ready/out_result/out_rd result handshake; busy = not idle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t st, st_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op_q;
  logic [XLEN-1:0] a_q, hi, lo;
  logic neg_q, negr_q;
  assign in_ready = st == IDLE;
  assign busy = st != IDLE;
  logic sgn1, sgn2, s1, s2, div_zero, ovf, special;
  logic [XLEN-1:0] m1, m2, special_res;
  assign sgn1 = in_op[2] ? ~in_op[0] : (in_op == 3'd1 || in_op == 3'd2);
  assign sgn2 = in_op[2] ? ~in_op[0] : (in_op == 3'd1);
  assign s1 = sgn1 & in_rs1[XLEN-1];
  assign s2 = sgn2 & in_rs2[XLEN-1];
  assign m1 = s1 ? -in_rs1 : in_rs1;
  assign m2 = s2 ? -in_rs2 : in_rs2;
  assign div_zero = in_op[2] & (in_rs2 == '0);
  assign ovf = in_op[2] & ~in_op[0] & (in_rs1 == MIN) & (in_rs2 == '1);
  assign special = div_zero | ovf;
  assign special_res = div_zero ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : MIN);
  // Multiply step: {hi,lo} starts as {0,multiplier}; add multiplicand into hi on lo[0], shift right.
  logic [XLEN:0] mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
  assign mul_hi = mul_sum[XLEN:1];
  assign mul_lo = {mul_sum[0], lo[XLEN-1:1]};
  // Restoring divide step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic [XLEN:0] r_sh, diff;
  logic fits;
  logic [XLEN-1:0] div_hi, div_lo;
  assign r_sh = {hi, lo[XLEN-1]};
  assign diff = r_sh - {1'b0, a_q};
  assign fits = r_sh >= {1'b0, a_q};
  assign div_hi = fits ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
  assign div_lo = {lo[XLEN-2:0], fits};
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0] quo, rem, fin_res;
  assign prod = {hi, lo};
  assign prod_c = neg_q ? -prod : prod;
  assign quo = neg_q ? -lo : lo;
  assign rem = negr_q ? -hi : hi;
  assign fin_res = op_q[2] ? (op_q[1] ? rem : quo) :
                   (op_q[1:0] == 2'd0 ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN]);
  always_comb begin
    st_nx = st;
    case (st)
      IDLE: st_nx = in_valid ? (special ? DONE : CALC) : IDLE;
      CALC: st_nx = cnt == CNT_W'(XLEN-1) ? FIN : CALC;
      FIN:  st_nx = DONE;
      DONE: st_nx = out_ready ? IDLE : DONE;
    endcase
    if (flush) st_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      hi <= '0;
      lo <= '0;
      neg_q <= 1'b0;
      negr_q <= 1'b0;
      out_valid <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          op_q <= in_op;
          out_rd <= in_rd;
          cnt <= '0;
          neg_q <= s1 ^ s2;
          negr_q <= s1;
          hi <= '0;
          a_q <= in_op[2] ? m2 : m1;
          lo <= in_op[2] ? m1 : m2;
          if (special) begin
            out_result <= special_res;
            out_valid <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          hi <= op_q[2] ? div_hi : mul_hi;
          lo <= op_q[2] ? div_lo : mul_lo;
        end
        FIN: begin
          out_result <= fin_res;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
      endcase
    end
endmodule
